// File: rtl/gol_pkg.sv
// Shared types and constants for the Game-of-Life generation controller.
package gol_pkg;

    localparam int DEF_ROWS = 8;
    localparam int DEF_COLS = 8;

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_PAUSE = 2'd1,
        ST_RUN   = 2'd2
    } gol_state_e;

    function automatic int idx_w(input int rows, input int cols);
        return ((rows * cols) > 1) ? $clog2(rows * cols) : 1;
    endfunction

endpackage

// File: rtl/gol_tick_div.sv
// Generation-rate divider: counts 0..TICK_DIV-1 while enabled and flags the wrap.
module gol_tick_div #(
    parameter int unsigned TICK_DIV = 25_000_000
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clr,
    input  logic i_en,
    output logic o_wrap
);

    localparam logic [31:0] LAST = 32'(TICK_DIV - 32'd1);

    logic [31:0] r_cnt;

    // Divider counter; clear wins over enable so it sits at zero outside RUN.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_cnt <= 32'd0;
        end else if (i_clr) begin
            r_cnt <= 32'd0;
        end else if (i_en) begin
            if (r_cnt == LAST) begin
                r_cnt <= 32'd0;
            end else begin
                r_cnt <= r_cnt + 32'd1;
            end
        end else begin
            r_cnt <= r_cnt;
        end
    end

    assign o_wrap = i_en & ~i_clr & (r_cnt == LAST);

endmodule

// File: rtl/gol_gen_ctrl.sv
// Seed loader and generation-tick sequencer for the Game-of-Life cell array.
module gol_gen_ctrl
    import gol_pkg::*;
#(
    parameter int          ROWS     = DEF_ROWS,
    parameter int          COLS     = DEF_COLS,
    parameter int unsigned TICK_DIV = 25_000_000,
    parameter int          GEN_W    = 16
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_load_valid,
    input  logic                   i_load_bit,
    output logic                   o_load_ready,
    input  logic                   i_run,
    input  logic                   i_step,
    input  logic                   i_reload,
    output logic [ROWS*COLS-1:0]   o_initial_state,
    output logic                   o_cell_rst_n,
    output logic                   o_gen_tick,
    output logic [GEN_W-1:0]       o_gen_count,
    output logic                   o_running
);

    localparam int                N_CELLS  = ROWS * COLS;
    localparam int                IDX_W    = idx_w(ROWS, COLS);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(N_CELLS - 1);

    gol_state_e            r_state;
    logic [IDX_W-1:0]      r_idx;
    logic [N_CELLS-1:0]    r_initial_state;
    logic                  r_load_ready;
    logic                  r_cell_rst_n;
    logic                  r_gen_tick;
    logic [GEN_W-1:0]      r_gen_count;
    logic                  r_running;
    logic                  r_step_q;
    logic                  w_step_rise;
    logic                  w_wrap;
    logic                  w_div_clr;
    logic                  w_div_en;

    assign w_step_rise = i_step & ~r_step_q;
    assign w_div_en    = (r_state == ST_RUN);
    assign w_div_clr   = (r_state != ST_RUN) | i_reload;

    gol_tick_div #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_div (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_clr   (w_div_clr),
        .i_en    (w_div_en),
        .o_wrap  (w_wrap)
    );

    // Controller FSM; reload pre-empts any transition or pending tick in the same cycle.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state         <= ST_LOAD;
            r_idx           <= '0;
            r_initial_state <= '0;
            r_load_ready    <= 1'b1;
            r_cell_rst_n    <= 1'b0;
            r_gen_tick      <= 1'b0;
            r_gen_count     <= '0;
            r_running       <= 1'b0;
            r_step_q        <= 1'b0;
        end else begin
            r_step_q   <= i_step;
            r_gen_tick <= 1'b0;
            if (i_reload) begin
                r_state      <= ST_LOAD;
                r_idx        <= '0;
                r_load_ready <= 1'b1;
                r_cell_rst_n <= 1'b0;
                r_gen_count  <= '0;
                r_running    <= 1'b0;
            end else begin
                case (r_state)
                    ST_LOAD: begin
                        if (i_load_valid && r_load_ready) begin
                            r_initial_state[r_idx] <= i_load_bit;
                            if (r_idx == LAST_IDX) begin
                                r_idx        <= '0;
                                r_state      <= ST_PAUSE;
                                r_load_ready <= 1'b0;
                                r_cell_rst_n <= 1'b1;
                            end else begin
                                r_idx <= r_idx + IDX_W'(1);
                            end
                        end
                    end
                    ST_PAUSE: begin
                        if (i_run) begin
                            r_state   <= ST_RUN;
                            r_running <= 1'b1;
                        end else if (w_step_rise) begin
                            r_gen_tick  <= 1'b1;
                            r_gen_count <= r_gen_count + GEN_W'(1);
                        end
                    end
                    ST_RUN: begin
                        if (!i_run) begin
                            r_state   <= ST_PAUSE;
                            r_running <= 1'b0;
                        end else if (w_wrap) begin
                            r_gen_tick  <= 1'b1;
                            r_gen_count <= r_gen_count + GEN_W'(1);
                        end
                    end
                    default: begin
                        r_state      <= ST_LOAD;
                        r_idx        <= '0;
                        r_load_ready <= 1'b1;
                        r_cell_rst_n <= 1'b0;
                        r_gen_count  <= '0;
                        r_running    <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign o_load_ready    = r_load_ready;
    assign o_initial_state = r_initial_state;
    assign o_cell_rst_n    = r_cell_rst_n;
    assign o_gen_tick      = r_gen_tick;
    assign o_gen_count     = r_gen_count;
    assign o_running       = r_running;

endmodule

// File: doc/gol_gen_ctrl.md
Name: gol_gen_ctrl

Overview:
- Upstream controller for the Game-of-Life cell array.
- Loads a seed pattern serially, row-major, into a flat initial_state vector and holds the array's cell reset (cell_rst_n) low while loading.
- After loading, issues one-cycle gen_tick pulses that the array wrapper uses as its clock enable. Pulses come either free-running from a divider or one per single-step request.
- Counts elapsed generations.

Parameters:
- ROWS, 8, grid rows
- COLS, 8, grid columns
- TICK_DIV, 25_000_000, clk cycles per generation in RUN; legal range 2..2^32-1
- GEN_W, 16, gen_count width

Ports:
- clk  in  1  system clock
- Rst  in  1  synchronous active-low reset
- load_valid  in  1  seed bit valid
- load_bit  in  1  seed bit (1 = alive)
- load_ready  out  1  block accepts a seed bit this cycle
- run  in  1  level: 1 = free-run, 0 = pause
- step  in  1  debounced level; each rising edge = one generation while paused
- reload  in  1  one-cycle pulse: abandon the current pattern and return to LOAD
- initial_state  out  ROWS*COLS  seed vector; bit r*COLS+c = cell (r,c)
- cell_rst_n  out  1  drives the array's Rst; low = cells take initial_state
- gen_tick  out  1  one-cycle generation enable
- gen_count  out  GEN_W  generations since the last load
- running  out  1  high in RUN state

Behaviour:
- Reset is synchronous and active-low on Rst. All state updates happen at posedge clk. All outputs are registered.
- Reset values:
  - FSM = LOAD, load index = 0
  - initial_state = 0, cell_rst_n = 0, load_ready = 1
  - gen_tick = 0, gen_count = 0, running = 0
  - divider = 0, step edge register = 0
- States:
  - LOAD: load_ready = 1, cell_rst_n = 0, no ticks.
    - Each cycle with load_valid & load_ready writes load_bit to initial_state[idx] and increments idx.
    - The accept of idx = ROWS*COLS-1 moves the FSM to PAUSE on the next cycle; idx returns to 0.
  - PAUSE: load_ready = 0, cell_rst_n = 1.
    - A step rising edge (step & ~step_q) produces gen_tick = 1 in the following cycle.
    - run = 1 moves the FSM to RUN with the divider cleared.
  - RUN: divider counts 0..TICK_DIV-1.
    - gen_tick = 1 in the cycle after the divider wraps, so the first tick occurs TICK_DIV cycles after entering RUN.
    - run = 0 moves the FSM to PAUSE; the divider is held at 0 in PAUSE.
- gen_count increments by 1 on every gen_tick and wraps modulo 2^GEN_W. It clears to 0 on entry to LOAD.
- reload in PAUSE or RUN:
  - Next state is LOAD, idx = 0, cell_rst_n = 0, gen_count = 0.
  - initial_state is retained, not cleared, until it is overwritten bit by bit.
- reload in LOAD restarts idx at 0.
- Priority in one cycle: Rst > reload > run/step transition > tick.
- Conflict cases:
  - In RUN, step edges are ignored.
  - If step and run rise in the same PAUSE cycle, the FSM goes to RUN and no step tick is issued.
  - A tick pending from a divider wrap or step edge in the cycle reload arrives is suppressed.
- load_valid outside LOAD is ignored and has no side effects.
- Reset mid-load discards partial progress: idx = 0 and initial_state = 0.
- gen_tick is never high while cell_rst_n = 0.

Decomposition:
- Shared package gol_pkg holds:
  - FSM enum {LOAD, PAUSE, RUN}
  - default ROWS/COLS constants
  - an idx width function, $clog2(ROWS*COLS)
- Natural sub-module: gol_tick_div. It is the TICK_DIV counter with clear and enable, and outputs the wrap pulse. Edge detection and the FSM stay in gol_gen_ctrl.

Test Plan:
- Seed load, ROWS=COLS=4:
  - Stimulus: after reset, stream 16 bits 0x0E00 LSB-first with load_valid always high.
  - Required: load_ready drops the cycle after the 16th accept; initial_state = 16'h0E00; cell_rst_n rises with PAUSE; gen_count = 0.
- Backpressure and gaps: toggle load_valid 1,0,1,0 during the load.
  - Required: only valid cycles advance idx; the final vector is identical to the ungapped load.
- Single step: in PAUSE, give 3 step rising edges spaced 5 cycles apart while step is held high 3 cycles each.
  - Required: exactly 3 gen_tick pulses, each 1 cycle after its edge; gen_count = 3.
- Free-run with TICK_DIV=4:
  - Stimulus: set run = 1 for 17 cycles, then run = 0.
  - Required: ticks at cycles 4, 8, 12 and 16 after RUN entry; gen_count = 4; no ticks after pause.
- Reload mid-run:
  - Stimulus: pulse reload in the same cycle a divider wrap is due.
  - Required: no gen_tick; next cycle LOAD, cell_rst_n = 0, gen_count = 0, load_ready = 1.
- Mid-load reset: assert Rst low after 7 accepted bits.
  - Required: initial_state = 0 and idx = 0; a subsequent full 16-bit load lands correctly from bit 0.
